// File: rtl/shift_add_multiplier_if.sv
// Handshake bundle for the shift-and-add multiplier.
//   in_valid/in_ready/a/b          : operand request channel (master -> slave)
//   out_valid/out_ready/product    : result channel (slave -> master)
//   busy                           : slave is iterating over multiplier bits
// master modport belongs to the requester/consumer, slave to the multiplier.
interface shift_add_multiplier_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] product;
  logic         busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// Multi-cycle unsigned shift-and-add multiplier returning the low N bits of
// a*b (identical to RV32 MUL for signed or unsigned operands).
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, highest priority
//   bus  : shift_add_multiplier_if.slave (operand/result handshakes, busy)
// One multiplier bit is examined per cycle; the combinational left shifter
// supplies a_reg << count, which is added into the accumulator when the
// current multiplier bit is set.
//
// state  | meaning
// S_IDLE | waiting for operands, in_ready=1, product holds last result
// S_BUSY | 32 accumulate cycles, one per multiplier bit
// S_DONE | product valid, held until out_ready

module left_shifter #(
  parameter int N = 32
) (
  input  logic [N-1:0]         in,
  input  logic [$clog2(N)-1:0] shamt,
  output logic [N-1:0]         shifted
);
  assign shifted = in << shamt;
endmodule

module shift_add_multiplier #(
  parameter int N = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_add_multiplier_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [4:0]   count_q, count_d;
  logic [N-1:0] acc_q, acc_d;
  logic [N-1:0] a_reg_q, a_reg_d;
  logic [N-1:0] b_reg_q, b_reg_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         busy_q, busy_d;
  logic [N-1:0] shifted;

  left_shifter #(.N(N)) u_shifter (
    .in      (a_reg_q),
    .shamt   (count_q),
    .shifted (shifted)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    a_reg_d = a_reg_q;
    b_reg_d = b_reg_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_reg_d = bus.a;
          b_reg_d = bus.b;
          acc_d   = '0;
          count_d = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // Carry out of bit N-1 is dropped: only the low N product bits matter.
        if (b_reg_q[count_q]) begin
          acc_d = acc_q + shifted;
        end
        if (count_q == 5'd31) begin
          count_d = '0;
          state_d = S_DONE;
        end else begin
          count_d = count_q + 5'd1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the next state.
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d == S_BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      acc_q       <= '0;
      a_reg_q     <= '0;
      b_reg_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      a_reg_q     <= a_reg_d;
      b_reg_q     <= b_reg_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.product   = acc_q;
endmodule
